// File: rtl/camera_emulator_pkg.sv
// Shared encodings for the camera emulator: pattern modes, sequencer states
// and the colour-bar palette.
package camera_emulator_pkg;

    typedef enum logic [1:0] {
        MODE_BARS  = 2'd0,
        MODE_GRAD  = 2'd1,
        MODE_SOLID = 2'd2,
        MODE_CHECK = 2'd3
    } mode_e;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_VSYNC  = 3'd1,
        S_VBACK  = 3'd2,
        S_ACTIVE = 3'd3,
        S_VFRONT = 3'd4
    } state_e;

    localparam logic [15:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [15:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [15:0] BAR_CYAN    = 16'h07FF;
    localparam logic [15:0] BAR_GREEN   = 16'h07E0;
    localparam logic [15:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [15:0] BAR_RED     = 16'hF800;
    localparam logic [15:0] BAR_BLUE    = 16'h001F;
    localparam logic [15:0] BAR_BLACK   = 16'h0000;

    function automatic logic [15:0] bar_color(input logic [2:0] idx);
        logic [15:0] c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/camera_pattern_gen.sv
// Test-pattern source: holds the pixel word for the next pixel to be sent.
// Loaded once per line at line_start (x=0) and once per pixel on pix_adv.
module camera_pattern_gen
    import camera_emulator_pkg::*;
#(
    parameter int H_ACTIVE = 160
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        line_start,
    input  logic        pix_adv,
    input  logic [7:2]  x,
    input  logic        y_b3,
    input  mode_e       mode,
    input  logic [15:0] color,
    output logic [15:0] pixel
);

    localparam int BAR_W = H_ACTIVE / 8;
    localparam logic [7:0] STEP_LAST = 8'(BAR_W - 1);

    logic [7:0]  bar_step_q, bar_step_d;
    logic [2:0]  bar_idx_q, bar_idx_d;
    logic        y3_q, y3_d;
    logic [15:0] pix_q, pix_d;
    logic        y3_sel;
    logic [15:0] pat;

    always_comb begin
        bar_step_d = bar_step_q;
        bar_idx_d  = bar_idx_q;
        y3_d       = y3_q;
        pix_d      = pix_q;
        pat        = 16'h0000;

        if (line_start) begin
            bar_step_d = 8'd0;
            bar_idx_d  = 3'd0;
            y3_d       = y_b3;
        end else if (pix_adv) begin
            if (bar_step_q == STEP_LAST) begin
                bar_step_d = 8'd0;
                bar_idx_d  = bar_idx_q + 3'd1;
            end else begin
                bar_step_d = bar_step_q + 8'd1;
            end
        end

        // Row parity is only known at line start; hold it for the rest of the line.
        y3_sel = line_start ? y_b3 : y3_q;

        case (mode)
            MODE_BARS:  pat = bar_color(bar_idx_d);
            MODE_GRAD:  pat = {x[7:3], x[7:2], x[7:3]};
            MODE_SOLID: pat = color;
            default:    pat = (x[3] ^ y3_sel) ? 16'h0000 : 16'hFFFF;
        endcase

        if (line_start || pix_adv) begin
            pix_d = pat;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bar_step_q <= 8'd0;
            bar_idx_q  <= 3'd0;
            y3_q       <= 1'b0;
            pix_q      <= 16'h0000;
        end else begin
            bar_step_q <= bar_step_d;
            bar_idx_q  <= bar_idx_d;
            y3_q       <= y3_d;
            pix_q      <= pix_d;
        end
    end

    assign pixel = pix_q;

endmodule

// File: rtl/camera_emulator.sv
// OV7670-style byte-serial RGB565 transmitter driving built-in test patterns.
//   state  | meaning
//   IDLE   | no frame; PCLK still runs, waits for EN
//   VSYNC  | VSYNC high for VS_LINES line times
//   VBACK  | VBP blank line times before the first active line
//   ACTIVE | V_ACTIVE lines: 2*H_ACTIVE bytes with HREF high, then H_BLANK
//   VFRONT | VFP blank line times, then count the frame and restart or idle
module camera_emulator
    import camera_emulator_pkg::*;
#(
    parameter int H_ACTIVE = 160,
    parameter int H_BLANK  = 16,
    parameter int VS_LINES = 3,
    parameter int VBP      = 2,
    parameter int V_ACTIVE = 120,
    parameter int VFP      = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic [1:0]  MODE,
    input  logic [15:0] COLOR,
    output logic        PCLK,
    output logic        VSYNC,
    output logic        HREF,
    output logic [7:0]  D,
    output logic [7:0]  FRAME_CNT,
    output logic        BUSY
);

    localparam int LT = 2 * H_ACTIVE + H_BLANK;
    localparam int BW = $clog2(LT);
    localparam logic [BW-1:0] BYTE_LAST = BW'(LT - 1);
    localparam logic [BW-1:0] HREF_END  = BW'(2 * H_ACTIVE);
    localparam logic [BW-1:0] ADV_END   = BW'(2 * H_ACTIVE - 1);

    logic          ph_q, ph_d;
    state_e        state_q, state_d;
    logic [BW-1:0] byte_q, byte_d, byte_inc;
    logic [7:0]    line_q, line_d, line_inc;
    mode_e         mode_q, mode_d;
    logic [15:0]   color_q, color_d;
    logic [7:0]    frame_q, frame_d;
    logic          vsync_q, vsync_d;
    logic          href_q, href_d;
    logic [7:0]    d_q, d_d;
    logic          busy_q, busy_d;

    logic [7:0]    phase_last;
    logic          line_end, phase_end, start_frame;
    logic          line_start, pix_adv;
    logic [7:2]    x_hi;
    logic          y_b3;
    logic [15:0]   pixel;

    always_comb begin
        case (state_q)
            S_VSYNC:  phase_last = 8'(VS_LINES - 1);
            S_VBACK:  phase_last = 8'(VBP - 1);
            S_ACTIVE: phase_last = 8'(V_ACTIVE - 1);
            S_VFRONT: phase_last = 8'(VFP - 1);
            default:  phase_last = 8'd0;
        endcase
    end

    always_comb begin
        ph_d        = ~ph_q;
        state_d     = state_q;
        byte_d      = byte_q;
        line_d      = line_q;
        mode_d      = mode_q;
        color_d     = color_q;
        frame_d     = frame_q;
        vsync_d     = vsync_q;
        href_d      = href_q;
        d_d         = d_q;
        busy_d      = busy_q;
        start_frame = 1'b0;
        line_start  = 1'b0;
        pix_adv     = 1'b0;
        x_hi        = 6'd0;
        y_b3        = 1'b0;

        byte_inc  = byte_q + BW'(1);
        line_inc  = line_q + 8'd1;
        line_end  = (byte_q == BYTE_LAST);
        phase_end = line_end && (line_q == phase_last);

        // Everything advances on the CLK edge where PCLK falls.
        if (ph_q) begin
            case (state_q)
                S_IDLE: start_frame = EN;
                default: begin
                    if (!line_end) begin
                        byte_d = byte_inc;
                    end else begin
                        byte_d = '0;
                        if (!phase_end) begin
                            line_d = line_inc;
                        end else begin
                            line_d = 8'd0;
                            case (state_q)
                                S_VSYNC:  state_d = S_VBACK;
                                S_VBACK:  state_d = S_ACTIVE;
                                S_ACTIVE: state_d = S_VFRONT;
                                default: begin
                                    frame_d = frame_q + 8'd1;
                                    if (EN) begin
                                        start_frame = 1'b1;
                                    end else begin
                                        state_d = S_IDLE;
                                    end
                                end
                            endcase
                        end
                    end
                end
            endcase

            if (start_frame) begin
                state_d = S_VSYNC;
                mode_d  = mode_e'(MODE);
                color_d = COLOR;
                byte_d  = '0;
                line_d  = 8'd0;
            end

            vsync_d = (state_d == S_VSYNC);
            busy_d  = (state_d != S_IDLE);
            href_d  = (state_d == S_ACTIVE) && (byte_d < HREF_END);
            d_d     = href_d ? (byte_d[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;

            // Preload pixel 0 during the last blank byte so it is ready as HREF rises;
            // on each low byte, fetch the following pixel.
            if ((state_d != S_IDLE) && (byte_d == BYTE_LAST)) begin
                line_start = 1'b1;
                y_b3       = (state_q == S_ACTIVE) ? line_inc[3] : 1'b0;
            end else if (href_d && byte_d[0] && (byte_d < ADV_END)) begin
                pix_adv = 1'b1;
                x_hi    = 6'((byte_d + BW'(2)) >> 3);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ph_q    <= 1'b0;
            state_q <= S_IDLE;
            byte_q  <= '0;
            line_q  <= 8'd0;
            mode_q  <= MODE_BARS;
            color_q <= 16'h0000;
            frame_q <= 8'd0;
            vsync_q <= 1'b0;
            href_q  <= 1'b0;
            d_q     <= 8'h00;
            busy_q  <= 1'b0;
        end else begin
            ph_q    <= ph_d;
            state_q <= state_d;
            byte_q  <= byte_d;
            line_q  <= line_d;
            mode_q  <= mode_d;
            color_q <= color_d;
            frame_q <= frame_d;
            vsync_q <= vsync_d;
            href_q  <= href_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
        end
    end

    camera_pattern_gen #(
        .H_ACTIVE (H_ACTIVE)
    ) u_pattern (
        .clk        (CLK),
        .rst        (RST),
        .line_start (line_start),
        .pix_adv    (pix_adv),
        .x          (x_hi),
        .y_b3       (y_b3),
        .mode       (mode_q),
        .color      (color_q),
        .pixel      (pixel)
    );

    assign PCLK      = ph_q;
    assign VSYNC     = vsync_q;
    assign HREF      = href_q;
    assign D         = d_q;
    assign FRAME_CNT = frame_q;
    assign BUSY      = busy_q;

endmodule
